// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock timeout/retry, lock filtering and design reset release.
module pll_reset_sequencer #(
    parameter int LOCK_FILTER    = 1024,
    parameter int HOLD_CYCLES    = 256,
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int PLL_RST_CYCLES = 16,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       reset_out,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retries
);
    localparam int MAX_A = LOCK_FILTER > HOLD_CYCLES ? LOCK_FILTER : HOLD_CYCLES;
    localparam int MAX_B = TIMEOUT_CYCLES > PLL_RST_CYCLES ? TIMEOUT_CYCLES : PLL_RST_CYCLES;
    localparam int MAX_P = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int CW = $clog2(MAX_P) + 1;
    localparam logic [CW-1:0] PRC_END = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] LF_END  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HC_END  = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    MAX_R   = 3'(MAX_RETRIES);
    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, FILTER, HOLD, RUN, FAIL} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic lock_m, lock_s, inc_retry;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end
    always_comb begin
        nxt = state;
        inc_retry = 1'b0;
        case (state)
            PLL_RST:   nxt = cnt == PRC_END ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: begin
                // lock has priority over a coincident timeout
                if (lock_s) nxt = FILTER;
                else if (cnt == TO_END) begin
                    nxt = retries >= MAX_R ? FAIL : PLL_RST;
                    inc_retry = retries < MAX_R;
                end
            end
            FILTER:    nxt = !lock_s ? WAIT_LOCK : cnt == LF_END ? HOLD : FILTER;
            HOLD:      nxt = !lock_s ? WAIT_LOCK : cnt == HC_END ? RUN : HOLD;
            RUN:       nxt = lock_s ? RUN : WAIT_LOCK;
            FAIL:      nxt = FAIL;
            default:   nxt = PLL_RST;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PLL_RST;
            cnt        <= '0;
            retries    <= 3'd0;
            pll_resetb <= 1'b0;
            reset_out  <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= nxt != state ? '0 : cnt + CW'(1);
            retries    <= (nxt == RUN && state != RUN) ? 3'd0 : inc_retry ? retries + 3'd1 : retries;
            pll_resetb <= !(nxt == PLL_RST || nxt == FAIL);
            reset_out  <= nxt != RUN;
            ready      <= nxt == RUN;
            fail       <= nxt == FAIL;
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed edge-numbered scenarios; edge n is the n-th rising edge after reset release.
module tb_pll_reset_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic pll_lock = 1'b0;
    logic pll_resetb, reset_out, ready, fail;
    logic [2:0] retries;
    int n_cmp = 0;
    int n_err = 0;
    int ec = 0;
    pll_reset_sequencer #(
        .LOCK_FILTER(4), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(20), .PLL_RST_CYCLES(2), .MAX_RETRIES(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock), .pll_resetb(pll_resetb),
        .reset_out(reset_out), .ready(ready), .fail(fail), .retries(retries)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, ec, obs, exp);
        end
    endtask
    // inputs change and outputs are sampled 1 time unit after edge e
    task automatic go_to(input int e);
        while (ec < e) begin
            @(posedge clock);
            ec++;
        end
        #1;
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_resetb"}, {2'b0, pll_resetb}, 3'd0);
        chk({tag, "_reset_out"}, {2'b0, reset_out}, 3'd1);
        chk({tag, "_ready"}, {2'b0, ready}, 3'd0);
        chk({tag, "_fail"}, {2'b0, fail}, 3'd0);
        chk({tag, "_retries"}, retries, 3'd0);
    endtask
    task automatic restart();
        reset_n = 1'b0;
        pll_lock = 1'b0;
        #7;
        chk_reset_vals("in_reset");
        @(negedge clock);
        reset_n = 1'b1;
        ec = 0;
    endtask
    initial begin
        // nominal lock, then lock loss in RUN and relock
        restart();
        go_to(1);  chk("nom_rstb_e1", {2'b0, pll_resetb}, 3'd0);
        go_to(2);  chk("nom_rstb_e2", {2'b0, pll_resetb}, 3'd1);
        go_to(5);  pll_lock = 1'b1;
        go_to(14); chk("nom_rout_e14", {2'b0, reset_out}, 3'd1);
                   chk("nom_ready_e14", {2'b0, ready}, 3'd0);
        go_to(15); chk("nom_rout_e15", {2'b0, reset_out}, 3'd0);
                   chk("nom_ready_e15", {2'b0, ready}, 3'd1);
                   chk("nom_rstb_e15", {2'b0, pll_resetb}, 3'd1);
        go_to(17); pll_lock = 1'b0;
        go_to(19); chk("loss_rout_e19", {2'b0, reset_out}, 3'd0);
        go_to(20); chk("loss_rout_e20", {2'b0, reset_out}, 3'd1);
                   chk("loss_ready_e20", {2'b0, ready}, 3'd0);
                   chk("loss_rstb_e20", {2'b0, pll_resetb}, 3'd1);
        go_to(22); pll_lock = 1'b1;
        go_to(31); chk("relock_rout_e31", {2'b0, reset_out}, 3'd1);
                   chk("relock_rstb_e31", {2'b0, pll_resetb}, 3'd1);
        go_to(32); chk("relock_rout_e32", {2'b0, reset_out}, 3'd0);
        // one-cycle glitch while filtering
        restart();
        go_to(5);  pll_lock = 1'b1;
        go_to(9);  pll_lock = 1'b0;
        go_to(10); pll_lock = 1'b1;
        go_to(15); chk("glitch_rout_e15", {2'b0, reset_out}, 3'd1);
        go_to(19); chk("glitch_rout_e19", {2'b0, reset_out}, 3'd1);
        go_to(20); chk("glitch_rout_e20", {2'b0, reset_out}, 3'd0);
                   chk("glitch_ready_e20", {2'b0, ready}, 3'd1);
        // lock never arrives: two retries then FAIL
        restart();
        go_to(21); chk("to_rstb_e21", {2'b0, pll_resetb}, 3'd1);
                   chk("to_retries_e21", retries, 3'd0);
        go_to(22); chk("to_rstb_e22", {2'b0, pll_resetb}, 3'd0);
                   chk("to_retries_e22", retries, 3'd1);
        go_to(23); chk("to_rstb_e23", {2'b0, pll_resetb}, 3'd0);
        go_to(24); chk("to_rstb_e24", {2'b0, pll_resetb}, 3'd1);
                   chk("to_rout_e24", {2'b0, reset_out}, 3'd1);
        go_to(43); chk("to_rstb_e43", {2'b0, pll_resetb}, 3'd1);
        go_to(44); chk("to_rstb_e44", {2'b0, pll_resetb}, 3'd0);
                   chk("to_retries_e44", retries, 3'd2);
        go_to(46); chk("to_rstb_e46", {2'b0, pll_resetb}, 3'd1);
        go_to(65); chk("to_fail_e65", {2'b0, fail}, 3'd0);
        go_to(66); chk("to_fail_e66", {2'b0, fail}, 3'd1);
                   chk("to_rstb_e66", {2'b0, pll_resetb}, 3'd0);
                   chk("to_rout_e66", {2'b0, reset_out}, 3'd1);
                   chk("to_retries_e66", retries, 3'd2);
        go_to(70); pll_lock = 1'b1;
        go_to(100); chk("to_fail_e100", {2'b0, fail}, 3'd1);
                    chk("to_rstb_e100", {2'b0, pll_resetb}, 3'd0);
                    chk("to_ready_e100", {2'b0, ready}, 3'd0);
        // async reset mid-HOLD after one retry
        restart();
        go_to(22); chk("ar_retries_e22", retries, 3'd1);
        go_to(25); pll_lock = 1'b1;
        go_to(33); chk("ar_rout_e33", {2'b0, reset_out}, 3'd1);
                   chk("ar_rstb_e33", {2'b0, pll_resetb}, 3'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("ar_async");
        @(posedge clock);
        #1;
        chk_reset_vals("ar_held");
        // lock and timeout coincide
        restart();
        go_to(19); pll_lock = 1'b1;
        go_to(22); chk("tie_retries_e22", retries, 3'd0);
                   chk("tie_rstb_e22", {2'b0, pll_resetb}, 3'd1);
        go_to(28); chk("tie_rout_e28", {2'b0, reset_out}, 3'd1);
        go_to(29); chk("tie_rout_e29", {2'b0, reset_out}, 3'd0);
                   chk("tie_ready_e29", {2'b0, ready}, 3'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
